// File: rtl/apb_mem_responder_if.sv
// APB bus bundle shared by the memory responder and its initiator.
// The master modport drives the request; the slave modport drives the response.
interface apb_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_responder.sv
// APB completer backed by a word-addressed RAM with programmable wait states.
// Optional feature macro: APB_RAND_WAIT_EN adds LFSR-driven random extra wait states.
module apb_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic clock,
    input  logic reset,
    apb_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return merged;
    endfunction

    state_t        state_r, state_nx_s;
    logic [4:0]    cnt_r, cnt_nx_s, load_s;
    logic [31:0]   addr_r, wdata_r;
    logic          write_r;
    logic [3:0]    strb_r;
    logic          capture_s, mem_we_s;
    logic          pready_r, pready_nx_s;
    logic [31:0]   prdata_r, prdata_nx_s;
    logic          pslverr_r, pslverr_nx_s;
    logic [31:0]   off_s;
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   mem_r [DEPTH_WORDS];
    logic          unused_s;

`ifdef APB_RAND_WAIT_EN
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    logic [7:0] lfsr_r;

    // Free-running LFSR supplying the random part of the wait count.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign load_s   = 5'(WAIT_CYCLES) + {3'b000, lfsr_r[1:0]};
    assign unused_s = ^{bus.pprot, off_s[1:0]};
`else
    assign load_s   = 5'(WAIT_CYCLES);
    assign unused_s = ^{bus.pprot, off_s[1:0], LFSR_SEED};
`endif

    assign off_s      = addr_r - BASE_ADDR;
    assign in_range_s = (off_s < SPAN);
    assign idx_s      = off_s[AW+1:2];

    // Next-state, counter and registered-output values for the transfer FSM.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        capture_s    = 1'b0;
        mem_we_s     = 1'b0;
        pready_nx_s  = 1'b0;
        prdata_nx_s  = 32'h0000_0000;
        pslverr_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = load_s;
                    capture_s  = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    state_nx_s = ST_IDLE;
                end else if (cnt_r != 5'd0) begin
                    cnt_nx_s = cnt_r - 5'd1;
                end else begin
                    state_nx_s  = ST_RESP;
                    pready_nx_s = 1'b1;
                    if (!in_range_s) begin
                        pslverr_nx_s = 1'b1;
                    end else if (write_r) begin
                        mem_we_s = 1'b1;
                    end else begin
                        prdata_nx_s = mem_r[idx_s];
                    end
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and registered bus response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            pready_r  <= 1'b0;
            prdata_r  <= 32'h0000_0000;
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            pready_r  <= pready_nx_s;
            prdata_r  <= prdata_nx_s;
            pslverr_r <= pslverr_nx_s;
        end
    end

    // Request fields latched in the setup phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r  <= 32'h0000_0000;
            write_r <= 1'b0;
            wdata_r <= 32'h0000_0000;
            strb_r  <= 4'h0;
        end else if (capture_s) begin
            addr_r  <= bus.paddr;
            write_r <= bus.pwrite;
            wdata_r <= bus.pwdata;
            strb_r  <= bus.pstrb;
        end
    end

    // RAM array: contents survive reset, but a write still pending at reset is dropped.
    always_ff @(posedge clock) begin
        if (mem_we_s && !reset) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata_r, strb_r);
        end
    end

    assign bus.pready  = pready_r;
    assign bus.prdata  = prdata_r;
    assign bus.pslverr = pslverr_r;
endmodule

// File: tb/tb_apb_mem_responder.sv
// Self-checking bench for apb_mem_responder: a scoreboard queue holds the
// expected response of every completed transfer, popped when pready is seen.
module tb_apb_mem_responder;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 256;
    localparam int          WAITS = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    resp_t       sb_q[$];
    logic [31:0] model_mem [DEPTH];

    always #5 clock = ~clock;

    apb_if bus();

    apb_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS), .LFSR_SEED(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic model_push(input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] off;
        int          idx;
        resp_t       r;
        off = addr - BASE;
        if (off < 32'(DEPTH * 4)) begin
            idx = int'(off >> 2);
            r.err = 1'b0;
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) model_mem[idx][i*8 +: 8] = data[i*8 +: 8];
                end
                r.data = 32'h0;
            end else begin
                r.data = model_mem[idx];
            end
        end else begin
            r.err  = 1'b1;
            r.data = 32'h0;
        end
        sb_q.push_back(r);
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        input logic [3:0] strb, input string name);
        resp_t e;
        int    lat;
        bit    seen;
        model_push(addr, wr, data, strb);
        @(posedge clock); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr;
        bus.pwrite = wr; bus.pwdata = data; bus.pstrb = strb;
        @(posedge clock); #1;
        bus.penable = 1'b1;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.pready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s timeout: pready never seen, required within 40 cycles", name);
        end else begin
`ifdef APB_RAND_WAIT_EN
            if (lat < 4 || lat > 7) begin
                fails++;
                $display("FAIL %s latency: got %0d, required 4..7", name, lat);
            end
`else
            if (lat != WAITS + 2) begin
                fails++;
                $display("FAIL %s latency: got %0d, required %0d", name, lat, WAITS + 2);
            end
`endif
            checks++;
            if (bus.prdata !== e.data) begin
                fails++;
                $display("FAIL %s prdata: got %h, required %h", name, bus.prdata, e.data);
            end
            checks++;
            if (bus.pslverr !== e.err) begin
                fails++;
                $display("FAIL %s pslverr: got %b, required %b", name, bus.pslverr, e.err);
            end
        end
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (bus.pready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL %s: pready got 1, required 0 for %0d cycles", name, cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = 32'h0; bus.pprot = 3'b000;
        bus.pwrite = 1'b0; bus.pwdata = 32'h0; bus.pstrb = 4'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.pready !== 1'b0 || bus.prdata !== 32'h0 || bus.pslverr !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got pready=%b prdata=%h pslverr=%b, required 0/0/0",
                     bus.pready, bus.prdata, bus.pslverr);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        xfer(BASE + 32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF, "basic_wr");
        xfer(BASE + 32'h4, 1'b0, 32'h0, 4'h0, "basic_rd");
        idle_cycle();
        @(negedge clock);
        checks++;
        if (bus.pready !== 1'b0) begin
            fails++;
            $display("FAIL pready_width: got %b one cycle after response, required 0", bus.pready);
        end
    endtask

    task automatic test_strobes();
        xfer(BASE + 32'h8, 1'b1, 32'h1122_3344, 4'hF, "strb_full");
        xfer(BASE + 32'h8, 1'b1, 32'hAABB_CCDD, 4'b0101, "strb_part");
        xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h0, "strb_rd");
        xfer(BASE + 32'hB, 1'b0, 32'h0, 4'h0, "strb_rd_unaligned");
        idle_cycle();
    endtask

    task automatic test_out_of_range();
        xfer(BASE, 1'b1, 32'h0BAD_F00D, 4'hF, "oor_init_w0");
        xfer(BASE + 32'h3FC, 1'b1, 32'h5A5A_A5A5, 4'hF, "oor_init_w255");
        xfer(BASE + 32'h400, 1'b1, 32'h5, 4'hF, "oor_wr_above");
        xfer(BASE + 32'h400, 1'b0, 32'h0, 4'h0, "oor_rd_above");
        xfer(BASE, 1'b0, 32'h0, 4'h0, "oor_w0_intact");
        xfer(32'h0FFF_FFFC, 1'b1, 32'h1234_5678, 4'hF, "oor_wr_below");
        xfer(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0, "oor_rd_below");
        xfer(BASE + 32'h3FC, 1'b0, 32'h0, 4'h0, "oor_w255_intact");
        idle_cycle();
    endtask

    task automatic test_abort();
        xfer(BASE + 32'h10, 1'b1, 32'hCAFE_0010, 4'hF, "abort_init");
        idle_cycle();
        @(posedge clock); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = BASE + 32'h10;
        bus.pwrite = 1'b1; bus.pwdata = 32'hFFFF_FFFF; bus.pstrb = 4'hF;
        @(posedge clock); #1;
        bus.penable = 1'b1;
        @(posedge clock); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        expect_quiet(8, "abort_no_pready");
        xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, "abort_word_intact");
        idle_cycle();
        @(posedge clock); #1;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = BASE + 32'h10; bus.pwrite = 1'b0;
        expect_quiet(8, "no_setup_ignored");
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        xfer(BASE + 32'h14, 1'b1, 32'h7777_1414, 4'hF, "rstmid_init");
        idle_cycle();
        @(posedge clock); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = BASE + 32'h14;
        bus.pwrite = 1'b1; bus.pwdata = 32'h0000_0000; bus.pstrb = 4'hF;
        @(posedge clock); #1;
        bus.penable = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.pready !== 1'b0 || bus.prdata !== 32'h0 || bus.pslverr !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: got pready=%b prdata=%h pslverr=%b, required 0/0/0",
                     bus.pready, bus.prdata, bus.pslverr);
        end
        expect_quiet(6, "rstmid_no_pready");
        xfer(BASE + 32'h14, 1'b0, 32'h0, 4'h0, "rstmid_no_write");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            xfer(BASE + 32'(32 + i * 4), 1'b1, $urandom, 4'(i + 7), "b2b_wr");
        end
        for (int i = 0; i < 4; i++) begin
            xfer(BASE + 32'(32 + i * 4), 1'b0, 32'h0, 4'h0, "b2b_rd");
        end
        idle_cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        test_reset();
        // Seed every word used later so the model and the RAM agree on known values.
        for (int i = 8; i < 12; i++) xfer(BASE + 32'(i * 4), 1'b1, 32'h0, 4'hF, "seed");
        idle_cycle();
        test_basic();
        test_strobes();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
